// File: rtl/polaris_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : polaris_bus_pkg
//  Description : Shared encodings for the Polaris I/D-to-shared-bus arbiter:
//                transfer sizes, FSM states, master identifiers and the
//                default watchdog limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package polaris_bus_pkg;

  typedef logic [1:0] siz_t;

  // Transfer size encodings; SIZ_NONE doubles as "no request" / "bus idle".
  localparam siz_t SIZ_NONE  = 2'b00;
  localparam siz_t SIZ_HALF  = 2'b01;
  localparam siz_t SIZ_WORD  = 2'b10;
  localparam siz_t SIZ_DWORD = 2'b11;

  // Cycles a granted transfer may wait for the slave before it is aborted.
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_e;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } master_e;

  // A nonzero size field is a request.
  function automatic logic siz_req(input siz_t siz);
    return siz != SIZ_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/polaris_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : polaris_bus_arbiter_if
//  Description : Instruction port, data port and shared-bus signals of the
//                Polaris arbiter. The slave modport is the arbiter's view
//                (it serves the CPU ports); the master modport is the view
//                of the CPU plus the shared-bus slave around it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface polaris_bus_arbiter_if;
  import polaris_bus_pkg::*;

  // Instruction-fetch port
  logic [63:0] iadr_i;
  siz_t        isiz_i;
  logic [31:0] idat_o;
  logic        iack_o;
  logic        ierr_o;

  // Data port
  logic [63:0] dadr_i;
  siz_t        dsiz_i;
  logic        dwe_i;
  logic [63:0] ddat_i;
  logic [63:0] ddat_o;
  logic        dack_o;
  logic        derr_o;

  // Shared bus
  logic [63:0] xadr_o;
  siz_t        xsiz_o;
  logic        xwe_o;
  logic [63:0] xdat_o;
  logic [63:0] xdat_i;
  logic        xack_i;

  modport slave (
    input  iadr_i, isiz_i, dadr_i, dsiz_i, dwe_i, ddat_i, xdat_i, xack_i,
    output idat_o, iack_o, ierr_o, ddat_o, dack_o, derr_o,
           xadr_o, xsiz_o, xwe_o, xdat_o
  );

  modport master (
    output iadr_i, isiz_i, dadr_i, dsiz_i, dwe_i, ddat_i, xdat_i, xack_i,
    input  idat_o, iack_o, ierr_o, ddat_o, dack_o, derr_o,
           xadr_o, xsiz_o, xwe_o, xdat_o
  );

endinterface
`default_nettype wire

// File: rtl/polaris_bus_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : polaris_bus_watchdog
//  Description : Grant watchdog. Counts cycles a granted transfer has waited
//                and flags expiry once the count equals TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module polaris_bus_watchdog
  import polaris_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: clear wins over increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/polaris_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : polaris_bus_arbiter
//  Description : Two-master (instruction fetch / data) arbiter onto a single
//                shared bus. Round-robin on contention, registered bus
//                outputs, same-cycle ack forwarding and a watchdog abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module polaris_bus_arbiter
  import polaris_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  polaris_bus_arbiter_if.slave  bus
);

  state_e      state_d, state_q;
  master_e     last_grant_d, last_grant_q;
  logic [63:0] xadr_d, xadr_q;
  siz_t        xsiz_d, xsiz_q;
  logic        xwe_d, xwe_q;
  logic [63:0] xdat_d, xdat_q;

  logic ireq, dreq;
  logic iack, dack, ierr, derr;
  logic wd_clear, wd_enable, wd_expired;

  assign ireq = siz_req(bus.isiz_i);
  assign dreq = siz_req(bus.dsiz_i);

  polaris_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  // Grant selection, completion/abort detection and bus-register next values.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    xadr_d       = xadr_q;
    xsiz_d       = xsiz_q;
    xwe_d        = xwe_q;
    xdat_d       = xdat_q;
    iack         = 1'b0;
    dack         = 1'b0;
    ierr         = 1'b0;
    derr         = 1'b0;
    wd_clear     = 1'b0;
    wd_enable    = 1'b0;

    case (state_q)
      IDLE: begin
        // Holding the counter at zero in IDLE makes every grant start fresh.
        wd_clear = 1'b1;
        // I wins when alone, or on contention when D was granted last.
        if (ireq && (!dreq || (last_grant_q == MST_D))) begin
          state_d      = IGNT;
          last_grant_d = MST_I;
          xadr_d       = bus.iadr_i;
          xsiz_d       = bus.isiz_i;
          xwe_d        = 1'b0;
          xdat_d       = '0;
        end else if (dreq) begin
          state_d      = DGNT;
          last_grant_d = MST_D;
          xadr_d       = bus.dadr_i;
          xsiz_d       = bus.dsiz_i;
          xwe_d        = bus.dwe_i;
          xdat_d       = bus.ddat_i;
        end
      end

      IGNT, DGNT: begin
        // An ack in the expiry cycle still completes the transfer normally.
        if (bus.xack_i) begin
          iack    = (state_q == IGNT);
          dack    = (state_q == DGNT);
          state_d = IDLE;
          xsiz_d  = SIZ_NONE;
        end else if (wd_expired) begin
          ierr    = (state_q == IGNT);
          derr    = (state_q == DGNT);
          state_d = IDLE;
          xsiz_d  = SIZ_NONE;
        end else begin
          wd_enable = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        xsiz_d  = SIZ_NONE;
      end
    endcase
  end

  // State, round-robin pointer and registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= MST_D;
      xadr_q       <= '0;
      xsiz_q       <= SIZ_NONE;
      xwe_q        <= 1'b0;
      xdat_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      xadr_q       <= xadr_d;
      xsiz_q       <= xsiz_d;
      xwe_q        <= xwe_d;
      xdat_q       <= xdat_d;
    end
  end

  // Strobes are suppressed under reset so an abandoned transfer reports nothing.
  assign bus.iack_o = iack & ~reset_i;
  assign bus.dack_o = dack & ~reset_i;
  assign bus.ierr_o = ierr & ~reset_i;
  assign bus.derr_o = derr & ~reset_i;
  assign bus.idat_o = bus.xdat_i[31:0];
  assign bus.ddat_o = bus.xdat_i;
  assign bus.xadr_o = xadr_q;
  assign bus.xsiz_o = xsiz_q;
  assign bus.xwe_o  = xwe_q;
  assign bus.xdat_o = xdat_q;

endmodule
`default_nettype wire

// File: tb/tb_polaris_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_polaris_bus_arbiter
//  Description : Scoreboard bench for polaris_bus_arbiter. Stimulus pushes
//                expected grants/acks/errors; a negedge monitor pops and
//                compares whenever the DUT presents one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_polaris_bus_arbiter;
  import polaris_bus_pkg::*;

  localparam int K_GRANT = 0;
  localparam int K_IACK  = 1;
  localparam int K_DACK  = 2;
  localparam int K_IERR  = 3;
  localparam int K_DERR  = 4;

  typedef struct {
    int          kind;
    logic [63:0] adr;
    logic [1:0]  siz;
    logic        we;
    logic [63:0] dat;
    int          gap;   // cycles from previous reference event, -1 = unchecked
  } exp_t;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  polaris_bus_arbiter_if bus();

  polaris_bus_arbiter #(
    .TIMEOUT (255)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  int        cyc       = 0;
  int        last_end  = 0;
  int        grant_cyc = 0;
  logic [1:0] prev_xsiz = 2'b00;
  bit        pend_idle = 1'b0;
  exp_t      cur;

  task automatic take(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind=%0d actual=present required=none", kind);
    end else begin
      e  = sb.pop_front();
      ok = 1'b1;
      chk("event_kind", 64'(kind), 64'(e.kind));
    end
  endtask

  task automatic end_event(input int kind, input logic [63:0] data);
    exp_t e;
    bit   ok;
    take(kind, e, ok);
    if (ok) begin
      if (kind == K_IACK || kind == K_DACK) chk("ack_data", data, e.dat);
      if (e.gap >= 0) chk("end_gap", 64'(cyc - grant_cyc), 64'(e.gap));
    end
    last_end  = cyc;
    pend_idle = 1'b1;
  endtask

  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (pend_idle) begin
        chk("bus_idle_after_end", 64'(bus.xsiz_o), 64'(SIZ_NONE));
        pend_idle = 1'b0;
      end
      if (bus.xsiz_o != 2'b00 && prev_xsiz == 2'b00) begin
        take(K_GRANT, e, ok);
        if (ok) begin
          chk("grant_adr", bus.xadr_o, e.adr);
          chk("grant_siz", 64'(bus.xsiz_o), 64'(e.siz));
          chk("grant_we", 64'(bus.xwe_o), 64'(e.we));
          chk("grant_dat", bus.xdat_o, e.dat);
          if (e.gap >= 0) chk("grant_gap", 64'(cyc - last_end), 64'(e.gap));
          cur = e;
        end
        grant_cyc = cyc;
      end else if (bus.xsiz_o != 2'b00) begin
        chk("hold_adr", bus.xadr_o, cur.adr);
        chk("hold_siz", 64'(bus.xsiz_o), 64'(cur.siz));
        chk("hold_we", 64'(bus.xwe_o), 64'(cur.we));
        chk("hold_dat", bus.xdat_o, cur.dat);
      end
      if (bus.iack_o) end_event(K_IACK, {32'h0, bus.idat_o});
      if (bus.dack_o) end_event(K_DACK, bus.ddat_o);
      if (bus.ierr_o) end_event(K_IERR, 64'h0);
      if (bus.derr_o) end_event(K_DERR, 64'h0);
      prev_xsiz = bus.xsiz_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int kind, input logic [63:0] adr, input logic [1:0] siz,
                      input logic we, input logic [63:0] dat, input int gap);
    exp_t e;
    e.kind = kind;
    e.adr  = adr;
    e.siz  = siz;
    e.we   = we;
    e.dat  = dat;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic ack_now(input int kind, input logic [63:0] data,
                         input logic [63:0] req, input int gap);
    push(kind, 64'h0, 2'b00, 1'b0, req, gap);
    bus.xdat_i = data;
    bus.xack_i = 1'b1;
    tick();
    bus.xack_i = 1'b0;
    bus.xdat_i = 64'h0;
  endtask

  initial begin
    bus.iadr_i = 64'h0;
    bus.isiz_i = 2'b00;
    bus.dadr_i = 64'h0;
    bus.dsiz_i = 2'b00;
    bus.dwe_i  = 1'b0;
    bus.ddat_i = 64'h0;
    bus.xdat_i = 64'h0;
    bus.xack_i = 1'b0;
    reset_i    = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_xsiz", 64'(bus.xsiz_o), 64'h0);
    chk("rst_xadr", bus.xadr_o, 64'h0);
    chk("rst_xwe", 64'(bus.xwe_o), 64'h0);
    chk("rst_xdat", bus.xdat_o, 64'h0);
    chk("rst_strobes", 64'({bus.iack_o, bus.dack_o, bus.ierr_o, bus.derr_o}), 64'h0);
    reset_i = 1'b0;
    tick();

    // Single instruction fetch
    bus.isiz_i = 2'b10;
    bus.iadr_i = 64'hFFFF_FFFF_FFFF_FF00;
    push(K_GRANT, 64'hFFFF_FFFF_FFFF_FF00, 2'b10, 1'b0, 64'h0, -1);
    #1 chk("xsiz_registered", 64'(bus.xsiz_o), 64'h0);
    tick();
    chk("xsiz_next_cycle", 64'(bus.xsiz_o), 64'h2);
    bus.isiz_i = 2'b00;
    bus.iadr_i = 64'h0000_0000_0000_1234;
    tick();
    ack_now(K_IACK, 64'h0000_0000_0000_0013, 64'h0000_0000_0000_0013, 1);
    tick();

    // Contention from reset: I, D, I, D with one idle cycle between
    reset_i = 1'b1;
    repeat (2) tick();
    reset_i = 1'b0;
    bus.isiz_i = 2'b10;
    bus.iadr_i = 64'h0000_0000_0000_1000;
    bus.dsiz_i = 2'b11;
    bus.dadr_i = 64'h0000_0000_0000_2000;
    bus.dwe_i  = 1'b0;
    bus.ddat_i = 64'h0000_0000_0000_5555;
    push(K_GRANT, 64'h1000, 2'b10, 1'b0, 64'h0, -1);
    tick();
    ack_now(K_IACK, 64'h1111_2222_3333_4444, 64'h0000_0000_3333_4444, 0);
    push(K_GRANT, 64'h2000, 2'b11, 1'b0, 64'h5555, 2);
    tick();
    ack_now(K_DACK, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0);
    push(K_GRANT, 64'h1000, 2'b10, 1'b0, 64'h0, 2);
    tick();
    ack_now(K_IACK, 64'hFFFF_0000_8765_4321, 64'h0000_0000_8765_4321, 0);
    push(K_GRANT, 64'h2000, 2'b11, 1'b0, 64'h5555, 2);
    tick();
    bus.isiz_i = 2'b00;
    bus.dsiz_i = 2'b00;
    ack_now(K_DACK, 64'hA5A5_A5A5_5A5A_5A5A, 64'hA5A5_A5A5_5A5A_5A5A, 0);
    tick();

    // Data write
    bus.dadr_i = 64'h0000_0000_0000_0124;
    bus.dsiz_i = 2'b11;
    bus.dwe_i  = 1'b1;
    bus.ddat_i = 64'hDEAD_BEEF_0000_1234;
    push(K_GRANT, 64'h124, 2'b11, 1'b1, 64'hDEAD_BEEF_0000_1234, -1);
    tick();
    bus.dsiz_i = 2'b00;
    bus.dwe_i  = 1'b0;
    bus.ddat_i = 64'h0;
    repeat (2) tick();
    ack_now(K_DACK, 64'hCAFE_F00D_0000_0001, 64'hCAFE_F00D_0000_0001, 2);
    tick();

    // Instruction fetch timeout: error in the 256th grant cycle (count = 255)
    bus.isiz_i = 2'b10;
    bus.iadr_i = 64'h0000_0000_0000_0040;
    push(K_GRANT, 64'h40, 2'b10, 1'b0, 64'h0, -1);
    push(K_IERR, 64'h0, 2'b00, 1'b0, 64'h0, 255);
    tick();
    bus.isiz_i = 2'b00;
    repeat (258) tick();

    // Ack on the expiry cycle wins over the error
    bus.isiz_i = 2'b10;
    bus.iadr_i = 64'h0000_0000_0000_0080;
    push(K_GRANT, 64'h80, 2'b10, 1'b0, 64'h0, -1);
    tick();
    bus.isiz_i = 2'b00;
    repeat (255) tick();
    ack_now(K_IACK, 64'h0000_0000_0BAD_F00D, 64'h0000_0000_0BAD_F00D, 255);
    repeat (2) tick();

    // Ack while idle is ignored
    bus.xack_i = 1'b1;
    bus.xdat_i = 64'h1;
    tick();
    chk("idle_ack_ignored", 64'({bus.iack_o, bus.dack_o}), 64'h0);
    tick();
    bus.xack_i = 1'b0;
    bus.xdat_i = 64'h0;
    tick();

    // Reset during a data grant
    bus.dsiz_i = 2'b01;
    bus.dadr_i = 64'h0000_0000_0000_0300;
    bus.dwe_i  = 1'b0;
    bus.ddat_i = 64'h0000_0000_0000_0077;
    push(K_GRANT, 64'h300, 2'b01, 1'b0, 64'h77, -1);
    tick();
    bus.dsiz_i = 2'b00;
    repeat (3) tick();
    reset_i    = 1'b1;
    bus.xack_i = 1'b1;
    bus.xdat_i = 64'h9;
    #2 chk("rst_mid_grant_strobes", 64'({bus.dack_o, bus.derr_o}), 64'h0);
    tick();
    chk("rst_mid_grant_idle", 64'(bus.xsiz_o), 64'h0);
    reset_i    = 1'b0;
    bus.xack_i = 1'b0;
    bus.xdat_i = 64'h0;
    bus.isiz_i = 2'b10;
    bus.iadr_i = 64'h0000_0000_0000_0500;
    bus.dsiz_i = 2'b11;
    bus.dadr_i = 64'h0000_0000_0000_0600;
    push(K_GRANT, 64'h500, 2'b10, 1'b0, 64'h0, -1);
    tick();
    bus.isiz_i = 2'b00;
    bus.dsiz_i = 2'b00;
    ack_now(K_IACK, 64'h0000_0000_0000_00AA, 64'h0000_0000_0000_00AA, 0);
    repeat (3) tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
